// File: rtl/lut5_loader.sv
// 5-input lookup table whose 32-bit truth table can be reloaded serially (LSB first) through a shadow register.
// Optional readback of the active table during a load: define LUT5_LOADER_READBACK_EN to add rb_data.
module lut5_loader #(
  parameter logic [31:0] INIT = 32'hAAAAAAAA
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] I,
  output logic       O,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic       ld_data,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       busy
`ifdef LUT5_LOADER_READBACK_EN
  ,
  output logic       rb_data
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] active_q, active_d;
  logic        o_q, o_d;
  logic        accept;

  // A start pulse in LOAD restarts the load, so its companion bit is never taken.
  assign accept = (state_q == LOAD) && ld_valid && !ld_start;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    // The commit edge forwards the shadow so O shows the new table right after COMMIT.
    o_d      = (state_q == COMMIT) ? shadow_q[I] : active_q[I];

    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          cnt_d   = 5'd0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          cnt_d = 5'd0;
        end else if (ld_valid) begin
          shadow_d[cnt_q] = ld_data;
          cnt_d           = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = COMMIT;
        end
      end
      COMMIT: begin
        active_d = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      // NOTE: the shadow and table are plain registers, so they take a reset value like any flop.
      shadow_q <= 32'd0;
      active_q <= INIT;
      o_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      o_q      <= o_d;
    end
  end

  assign O        = o_q;
  assign ld_ready = (state_q == LOAD);
  assign ld_done  = (state_q == COMMIT);
  assign busy     = (state_q != IDLE);

`ifdef LUT5_LOADER_READBACK_EN
  assign rb_data = accept ? active_q[cnt_q] : 1'b0;
`endif

endmodule

// File: tb/tb_lut5_loader.sv
// Scoreboard bench for lut5_loader: stimulus tasks queue expected outputs per cycle, a negedge monitor compares.
// Define LUT5_LOADER_READBACK_EN for both files to also check the rb_data stream.
module tb_lut5_loader;

  localparam logic [31:0] INIT_VAL = 32'hAAAAAAAA;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] I;
  logic       O;
  logic       ld_start;
  logic       ld_valid;
  logic       ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic       busy;
`ifdef LUT5_LOADER_READBACK_EN
  logic       rb_data;
`endif

  lut5_loader #(.INIT(INIT_VAL)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .I        (I),
    .O        (O),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .busy     (busy)
`ifdef LUT5_LOADER_READBACK_EN
    ,
    .rb_data  (rb_data)
`endif
  );

  initial forever #5 CLK = ~CLK;

  typedef enum {K_O, K_DONE, K_BUSY, K_READY, K_RB} kind_t;
  typedef struct {
    int    cyc;
    kind_t kind;
    logic  val;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc     = 0;
  int          n_check = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] model   = INIT_VAL;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input kind_t k, input logic v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops every expectation due this cycle; ld_done must stay low unless a pulse is expected.
  always @(negedge CLK) begin
    exp_t e;
    bit   saw_done;
    logic act;
    saw_done = 1'b0;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_O:     act = O;
          K_DONE:  begin act = ld_done; saw_done = 1'b1; end
          K_BUSY:  act = busy;
          K_READY: act = ld_ready;
`ifdef LUT5_LOADER_READBACK_EN
          K_RB:    act = rb_data;
`endif
          default: act = 1'bx;
        endcase
        check((e.cyc < cyc) ? {"stale_", e.kind.name()} : e.kind.name(), act, e.val);
      end
      if (!saw_done) check("no_spurious_done", ld_done, 1'b0);
    end
  end

  task automatic idle_inputs();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle_inputs();
    step();
    mon_en = 1'b1;
    model  = INIT_VAL;
    push(cyc, K_O, 1'b0);
    push(cyc, K_BUSY, 1'b0);
    push(cyc, K_READY, 1'b0);
    RESET = 1'b0;
    step();
  endtask

  task automatic lookup(input logic [4:0] addr);
    I = addr;
    push(cyc + 1, K_O, model[addr]);
    step();
  endtask

  // commit_mode: 0 plain commit, 1 ld_start during COMMIT, 2 RESET during COMMIT.
  task automatic load(input logic [31:0] v, input int n_bits, input bit gaps,
                      input int commit_mode, input logic [4:0] probe);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = ~v[0];
`ifdef LUT5_LOADER_READBACK_EN
    push(cyc, K_RB, 1'b0);
`endif
    step();
    ld_start = 1'b0;
    push(cyc, K_BUSY, 1'b1);
    for (int k = 0; k < n_bits; k++) begin
      if (gaps && (k % 5 == 2)) begin
        for (int g = 0; g <= k % 3; g++) begin
          ld_valid = 1'b0;
          ld_data  = ~v[k];
          push(cyc, K_BUSY, 1'b1);
          push(cyc, K_READY, 1'b1);
`ifdef LUT5_LOADER_READBACK_EN
          push(cyc, K_RB, 1'b0);
`endif
          step();
        end
      end
      ld_valid = 1'b1;
      ld_data  = v[k];
      push(cyc, K_READY, 1'b1);
`ifdef LUT5_LOADER_READBACK_EN
      push(cyc, K_RB, model[k]);
`endif
      if (k == 31) begin
        I = probe;
        push(cyc + 1, K_O, model[probe]);
      end
      step();
    end
    ld_valid = 1'b0;
    if (n_bits == 32) begin
      push(cyc, K_DONE, 1'b1);
      push(cyc, K_BUSY, 1'b1);
      push(cyc, K_READY, 1'b0);
      if (commit_mode == 1) ld_start = 1'b1;
      if (commit_mode == 2) begin
        RESET = 1'b1;
        model = INIT_VAL;
        push(cyc + 1, K_O, 1'b0);
      end else begin
        model = v;
        push(cyc + 1, K_O, v[probe]);
      end
      step();
      ld_start = 1'b0;
      RESET    = 1'b0;
      push(cyc, K_BUSY, 1'b0);
      push(cyc, K_READY, 1'b0);
    end
  endtask

  initial begin
    I = 5'd0;
    idle_inputs();
    do_reset();
    lookup(5'd0);
    lookup(5'd1);

    // Single set bit at the top; readback of the first load must stream INIT.
    load(32'h80000000, 32, 1'b0, 0, 5'd31);
    lookup(5'd31);
    lookup(5'd30);

    // Gapped load with a start pulse during COMMIT that must be ignored.
    load(32'h0000FFFF, 32, 1'b1, 1, 5'd15);
    lookup(5'd16);
    lookup(5'd0);

    // Reset after 10 bits, with a valid bit presented alongside reset.
    load(32'h00000000, 10, 1'b0, 0, 5'd0);
    RESET    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 1'b0;
    step();
    model = INIT_VAL;
    push(cyc, K_O, 1'b0);
    push(cyc, K_BUSY, 1'b0);
    push(cyc, K_READY, 1'b0);
    RESET = 1'b0;
    idle_inputs();
    step();
    lookup(5'd1);

    // Restart after 20 bits of ones, then a full load.
    load(32'hFFFFFFFF, 20, 1'b0, 0, 5'd0);
    load(32'h55555555, 32, 1'b0, 0, 5'd0);
    lookup(5'd0);
    lookup(5'd1);
    lookup(5'd19);

    // Reset landing in the COMMIT cycle leaves the table at INIT.
    load(32'h00000000, 32, 1'b0, 2, 5'd3);
    lookup(5'd3);
    lookup(5'd4);

    step();
    step();
    check("queue_drained", exp_q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/lut5_loader.md
LUT5_LOADER -- requirements
Module: lut5_loader

Interface
REQ-001 Parameter INIT, default 32'hAAAAAAAA, is the active truth table after reset; bit k is the output for address k.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 I  input  5  lookup address.
REQ-005 O  output  1  registered lookup result.
REQ-006 ld_start  input  1  begins a table load.
REQ-007 ld_valid  input  1  ld_data is valid this cycle.
REQ-008 ld_data  input  1  serial table bit.
REQ-009 ld_ready  output  1  block accepts a bit this cycle.
REQ-010 ld_done  output  1  one-cycle pulse when a new table becomes active.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL have three states: IDLE, LOAD, COMMIT.
REQ-013 The block SHALL hold a 32-bit active table, a 32-bit shadow register and a 5-bit bit counter.
REQ-014 O SHALL equal active_table[I] sampled at the previous edge (latency 1 cycle), in every state.
REQ-015 IDLE, ld_start=1: next state LOAD, counter cleared to 0; ld_valid in that cycle SHALL be ignored.
REQ-016 ld_ready SHALL be 1 only in LOAD.
REQ-017 A bit is accepted when ld_valid & ld_ready: shadow[counter] <= ld_data, counter += 1; bits arrive LSB first (table bit 0 first).
REQ-018 ld_valid low in LOAD SHALL stall with no state change; gaps are unlimited.
REQ-019 The acceptance at counter==31 SHALL move to COMMIT; the counter wraps to 0 and is not reused.
REQ-020 In COMMIT, active_table <= shadow, ld_done=1 for that single cycle, and the next state is IDLE.
REQ-021 O SHALL reflect the old table through the COMMIT cycle and the new table from the following cycle.
REQ-022 ld_start in LOAD SHALL restart the load: counter=0, stays in LOAD, and any bit in the same cycle SHALL be discarded.
REQ-023 ld_start in COMMIT SHALL be ignored.
REQ-024 Unloaded shadow bits carry no meaning; an aborted load SHALL never alter the active table.

Reset
REQ-025 RESET SHALL force state IDLE, counter 0, shadow 0 and active_table INIT.
REQ-026 RESET SHALL force O=0, ld_ready=0, ld_done=0 and busy=0.
REQ-027 RESET SHALL take priority over all other inputs, including mid-load and in the COMMIT cycle; a commit interrupted by RESET SHALL leave the table at INIT.

Configuration
REQ-028 With macro LUT5_LOADER_READBACK_EN defined, the block SHALL add output rb_data (1 bit); when a bit is accepted at index k, rb_data SHALL equal active_table[k] in that same cycle, and 0 otherwise.
REQ-029 With LUT5_LOADER_READBACK_EN undefined, port rb_data SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then I=0 -> O=0; I=1 -> O=1 one cycle later (INIT AAAAAAAA).
REQ-031 Load 32'h80000000 with continuous ld_valid -> ld_done pulses exactly 1 cycle after the 32nd bit; then I=31 -> O=1 and I=30 -> O=0.
REQ-032 Load 32'h0000FFFF with random ld_valid gaps -> same final table; busy is high from the cycle after ld_start through COMMIT.
REQ-033 Assert RESET after 10 accepted bits of 32'h00000000 -> state IDLE, no ld_done, I=1 -> O=1 (INIT restored).
REQ-034 ld_start reasserted after 20 bits, then a full 32-bit load of 32'h55555555 -> I=0 gives O=1; the first 20 bits have no effect.
REQ-035 With READBACK_EN defined, after reset load any table -> rb_data stream equals 32'hAAAAAAAA LSB first.
